// File: rtl/hwjsoc_cpu_d_ocimem_ctrl.sv
// Debug-memory access controller: single-word Avalon-MM reads/writes driven by JTAG strobes.
// Optional stall timeout is enabled by defining OCIMEM_TIMEOUT_EN.
module hwjsoc_cpu_d_ocimem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic [8:0]  MonAReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic [10:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e      state_q, state_d;
    logic        inc_q, inc_d;
    logic [31:0] mon_d_q, mon_d_d;
    logic [8:0]  mon_a_q, mon_a_d;
    logic        ready_q, ready_d;
    logic        unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

`ifdef OCIMEM_TIMEOUT_EN
    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);

    logic       error_q, error_d;
    logic [9:0] cnt_q, cnt_d;
`else
    logic [9:0] unused_timeout;

    assign unused_timeout = 10'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        mon_d_d = mon_d_q;
        mon_a_d = mon_a_q;
        ready_d = ready_q;
`ifdef OCIMEM_TIMEOUT_EN
        error_d = error_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (take_action_ocimem_a) begin
                    mon_a_d = jdo[25:17];
                    if (jdo[34]) begin
                        state_d = StRead;
                        inc_d   = 1'b0;
                        ready_d = 1'b0;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    mon_d_d = jdo[34:3];
                    state_d = StWrite;
                    inc_d   = 1'b1;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = StRead;
                    inc_d   = 1'b1;
                    ready_d = 1'b0;
                end
`ifdef OCIMEM_TIMEOUT_EN
                if (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a) begin
                    error_d = 1'b0;
                    cnt_d   = '0;
                end
`endif
            end
            StRead, StWrite: begin
                if (!avm_waitrequest) begin
                    if (state_q == StRead) begin
                        mon_d_d = avm_readdata;
                    end
                    if (inc_q) begin
                        mon_a_d = mon_a_q + 9'd1;
                    end
                    ready_d = 1'b1;
                    state_d = StIdle;
`ifdef OCIMEM_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    // Abort leaves data and address registers untouched.
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 10'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            inc_q   <= 1'b0;
            mon_d_q <= '0;
            mon_a_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            mon_d_q <= mon_d_d;
            mon_a_q <= mon_a_d;
            ready_q <= ready_d;
        end
    end

`ifdef OCIMEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    assign monitor_error = error_q;
`else
    assign monitor_error = 1'b0;
`endif

    assign MonDReg        = mon_d_q;
    assign MonAReg        = mon_a_q;
    assign monitor_ready  = ready_q;
    assign avm_address    = {mon_a_q, 2'b00};
    assign avm_writedata  = mon_d_q;
    assign avm_byteenable = 4'hF;
    // Requests decode straight from the state flop, so reset drops them immediately.
    assign avm_read       = (state_q == StRead);
    assign avm_write      = (state_q == StWrite);

endmodule
